// File: rtl/pipeline_output_fifo.sv
// Credit-tracking output FIFO for a valid-only pipeline: captures output beats and re-presents them ready/valid.
// Optional same-cycle bypass when empty: define PIPELINE_OUTPUT_FIFO_BYPASS_EN.
module pipeline_output_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_issue,
  input  logic [WIDTH-1:0]           i_in_data,
  input  logic                       i_in_valid,
  output logic [WIDTH-1:0]           o_out_data,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic                       o_can_issue,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_protocol_err
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH-1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr, r_rd;
  logic [CW-1:0]    r_count, r_infl;
  logic             r_err;

  logic w_empty, w_full, w_pop, w_push, w_byp, w_byp_take;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL);
  assign w_pop   = !w_empty && i_out_ready;

`ifdef PIPELINE_OUTPUT_FIFO_BYPASS_EN
  assign w_byp       = w_empty && i_in_valid;
  assign w_byp_take  = w_byp && i_out_ready;
  assign o_out_valid = !w_empty || w_byp;
  assign o_out_data  = w_byp ? i_in_data : r_mem[r_rd];
`else
  assign w_byp       = 1'b0;
  assign w_byp_take  = w_byp;
  assign o_out_valid = !w_empty;
  assign o_out_data  = r_mem[r_rd];
`endif

  // A bypassed beat taken by the consumer never touches storage.
  assign w_push = i_in_valid && !w_byp_take && (!w_full || w_pop);

  assign o_can_issue    = ({1'b0, r_count} + {1'b0, r_infl}) < (CW+1)'(DEPTH);
  assign o_count        = r_count;
  assign o_protocol_err = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr] <= i_in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == LAST) ? '0 : r_wr + PW'(1);
      if (w_pop)  r_rd <= (r_rd == LAST) ? '0 : r_rd + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // In-flight beats saturate at both ends rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_infl <= '0;
    end else begin
      case ({i_issue, i_in_valid})
        2'b10:   if (r_infl != FULL) r_infl <= r_infl + CW'(1);
        2'b01:   if (r_infl != '0)   r_infl <= r_infl - CW'(1);
        default: r_infl <= r_infl;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if ((i_issue && !o_can_issue) ||
                 (i_in_valid && r_infl == '0) ||
                 (i_in_valid && w_full && !w_pop)) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_output_fifo.sv
// Directed + random bench for pipeline_output_fifo against a queue-based credit/FIFO model.
module tb_pipeline_output_fifo;
  localparam int DEPTH = 4;
`ifdef PIPELINE_OUTPUT_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue, in_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic        out_valid, can_issue, perr;
  logic [2:0]  count;

  pipeline_output_fifo #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .i_issue(issue), .i_in_data(in_data),
    .i_in_valid(in_valid), .o_out_data(out_data), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_can_issue(can_issue), .o_count(count),
    .o_protocol_err(perr)
  );

  always #5 clk = ~clk;

  logic [31:0] q[$];
  int          infl;
  bit          err;
  int          total = 0;
  int          bad = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_can_issue", {31'd0, can_issue}, 32'd1);
    chk("rst_protocol_err", {31'd0, perr}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    q.delete();
    infl = 0;
    err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(bit iss, bit v, logic [31:0] d, bit rdy);
    bit byp, exp_valid, can;
    issue = iss; in_valid = v; in_data = d; out_ready = rdy;
    #1;
    byp       = BYP && (q.size() == 0) && v;
    exp_valid = (q.size() != 0) || byp;
    can       = (q.size() + infl) < DEPTH;
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    if (exp_valid) chk("out_data", out_data, (q.size() != 0) ? q[0] : d);
    chk("count", {29'd0, count}, q.size());
    chk("can_issue", {31'd0, can_issue}, {31'd0, can});
    chk("protocol_err", {31'd0, perr}, {31'd0, err});
    @(posedge clk);
    if (iss && !can) err = 1'b1;
    if (v && infl == 0) err = 1'b1;
    if (byp) begin
      if (!rdy) q.push_back(d);
    end else begin
      if (rdy && q.size() != 0) void'(q.pop_front());
      if (v) begin
        if (q.size() < DEPTH) q.push_back(d);
        else err = 1'b1;
      end
    end
    if (iss && !v && infl < DEPTH) infl++;
    else if (v && !iss && infl > 0) infl--;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1; issue = 0; in_valid = 0; in_data = 0; out_ready = 0;
    @(negedge clk);
    do_reset();

    // credit limit, then fill with 0x10..0x13
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    chk("credit_exhausted", {31'd0, can_issue}, 32'd0);
    for (int i = 0; i < 4; i++) step(0, 1, 32'h10 + i, 0);
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_no_credit", {31'd0, can_issue}, 32'd0);

    // issue violation while full, then simultaneous pop/push at full
    step(1, 0, 0, 0);
    step(0, 1, 32'hAA, 1);
    chk("pushpop_count", {29'd0, count}, 32'd4);
    chk("err_from_issue", {31'd0, perr}, 32'd1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);

    // spurious beat with nothing in flight
    do_reset();
    step(0, 1, 32'h77, 0);
    chk("spurious_err", {31'd0, perr}, 32'd1);
    step(0, 0, 0, 0);
    chk("spurious_err_sticky", {31'd0, perr}, 32'd1);

    // overflow: full, then a push with no pop is dropped
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 32'h20 + i, 0);
    step(0, 1, 32'hDEAD, 0);
    chk("overflow_count", {29'd0, count}, 32'd4);
    chk("overflow_err", {31'd0, perr}, 32'd1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

    // bypass / baseline latency when empty
    do_reset();
    step(1, 0, 0, 1);
    step(0, 1, 32'h55, 1);
    chk("byp_count_after", {29'd0, count}, BYP ? 32'd0 : 32'd1);
    step(0, 0, 0, 1);

    // reset mid-traffic with two stored beats
    step(1, 0, 0, 0);
    step(1, 1, 32'h31, 0);
    step(0, 1, 32'h32, 0);
    chk("pre_reset_count", {29'd0, count}, 32'd2);
    do_reset();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      bit can, iss, v, rdy;
      can = (q.size() + infl) < DEPTH;
      iss = can ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 39) == 0);
      v   = (infl > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 99) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      step(iss, v, $urandom, rdy);
      if (n == 200) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipeline_output_fifo.md
# pipeline_output_fifo

Downstream adapter for generated valid-only pipeline wrappers: captures each `out`/`output_valid` beat from the pipeline into a small FIFO and re-presents it on a ready/valid interface. Because the pipeline has no backpressure, the block keeps credit accounting (stored + in-flight beats) and drives `can_issue`, which upstream uses to gate the pipeline's `input_valid`. It sits between the pipeline wrapper's registered outputs and any consumer that can stall.

## Interface
- `WIDTH`, 32, data width; must match the pipeline's `out` width.
- `DEPTH`, 4, FIFO entries; also the credit limit; must be ≥ 1.

- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `issue`  input  1  high in the cycle upstream asserts the pipeline's `input_valid`.
- `in_data`  input  WIDTH  pipeline `out`.
- `in_valid`  input  1  pipeline `output_valid`.
- `out_data`  output  WIDTH  head-of-FIFO data.
- `out_valid`  output  1  head entry available.
- `out_ready`  input  1  consumer accepts the beat when `out_valid` is also high.
- `can_issue`  output  1  high when `count + inflight < DEPTH`.
- `count`  output  $clog2(DEPTH+1)  stored entries.
- `protocol_err`  output  1  sticky error flag.

## Operation
- State:
  - circular storage of DEPTH × WIDTH;
  - read and write pointers, each wrapping at DEPTH−1 → 0 (non-power-of-2 DEPTH supported);
  - `count`;
  - `inflight` counter (same width as `count`);
  - `protocol_err`.
- Push: `in_valid` writes `in_data` at the write pointer.
- Pop: `out_valid && out_ready` advances the read pointer.
- `count` next = `count` + push − pop. A simultaneous push and pop leaves `count` unchanged and is legal when full.
- `inflight` next = `inflight` + `issue` − `in_valid`. It saturates at DEPTH and at 0 and never wraps.
- `can_issue` is combinational from registered `count` and `inflight`.
- `out_valid` = (`count` != 0). `out_data` = storage[read pointer].
- `protocol_err` is set, and held until reset, on any of:
  - `issue` while `can_issue` = 0 (the beat is still counted, with saturation);
  - `in_valid` while `inflight` = 0;
  - push while `count` = DEPTH and no pop in the same cycle. The beat is dropped: no write, pointer and `count` unchanged.
- A pop is only possible when `out_valid` is high, so underflow cannot occur.
- Reset (asynchronous assert, synchronous deassert handled externally), which also discards any beats in flight inside the pipeline:
  - pointers, `count`, `inflight` = 0;
  - `protocol_err` = 0;
  - `out_valid` = 0;
  - `can_issue` = 1;
  - `out_data` = 0 (storage cleared).

## Timing
- Baseline (no bypass): `in_valid` at edge-cycle t gives `out_valid` = 1 in cycle t+1, so latency is 1 cycle.
- Throughput is one beat per cycle in and out when `out_ready` is held high.
- `can_issue` updates one cycle after the `issue` or pop that changes the credit count.
- `issue` and `in_valid` in the same cycle: `inflight` is unchanged.
- Consumer stall: with `out_ready` = 0, `out_valid` and `out_data` hold stable until the beat is accepted.

## Configuration
- `PIPELINE_OUTPUT_FIFO_BYPASS_EN` defined:
  - when `count` = 0 and `in_valid` = 1, `out_valid` = 1 in the same cycle and `out_data` = `in_data`;
  - if `out_ready` is also high, the beat is consumed without being written (no `count` change), and `inflight` still decrements;
  - latency becomes 0 cycles when empty.
- Not defined: the baseline 1-cycle registered path only, with no combinational path from `in_*` to `out_*`.

## Test plan
All scenarios use WIDTH=32, DEPTH=4.
- Reset: hold `rst_n` low mid-traffic with `count`=2 → immediately `out_valid`=0, `count`=0, `can_issue`=1, `protocol_err`=0.
- Credit limit: 4 `issue` pulses, `in_valid` held 0, `out_ready`=0 → `can_issue` goes low the cycle after the 4th `issue`. Then deliver 4 beats 0x10..0x13 → `count`=4, `can_issue` stays 0.
- Drain in order: from full 0x10..0x13, hold `out_ready`=1 → `out_data` 0x10, 0x11, 0x12, 0x13 on consecutive cycles; `can_issue` returns to 1 after the first pop.
- Full with simultaneous push and pop: full with one extra `issue` violation, pop and push 0xAA in the same cycle → `count` stays 4, `protocol_err` set by the issue only, and 0xAA emerges after 0x13.
- Overflow and spurious input:
  - `in_valid` with `inflight`=0 → `protocol_err`=1 and stays 1;
  - push when full with no pop → beat dropped, `count`=4.
- Bypass (macro defined): empty, `in_valid`=1 with `in_data`=0x55, `out_ready`=1 → `out_valid`=1 and `out_data`=0x55 in the same cycle, then `count`=0.
- Bypass (macro undefined): same stimulus → `out_valid` rises one cycle later.
